// File: rtl/stack_pop_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_pop_sequencer_if
// Purpose  : Request, memory-read and result bundle for the stack pop sequencer.
// Revision : 1.0
// ============================================================================
interface stack_pop_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter int FLAG_W = 4
);
    logic                  start;
    logic                  is_rti;
    logic [ADDR_W-1:0]     sp_in;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_rd_data;
    logic                  busy;
    logic                  done;
    logic [2*DATA_W-1:0]   pc_out;
    logic [FLAG_W-1:0]     flags_out;
    logic                  flags_we;
    logic [ADDR_W-1:0]     sp_out;
    logic                  sp_we;

    // The sequencer side drives the memory read and the results.
    modport master (
        input  start, is_rti, sp_in, mem_rd_data,
        output mem_rd_en, mem_addr, busy, done, pc_out, flags_out, flags_we,
               sp_out, sp_we
    );

    modport slave (
        output start, is_rti, sp_in, mem_rd_data,
        input  mem_rd_en, mem_addr, busy, done, pc_out, flags_out, flags_we,
               sp_out, sp_we
    );
endinterface
`default_nettype wire

// File: rtl/stack_pop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_pop_sequencer
// Purpose  : Pops RET/RTI return frames from the stack, one word per cycle.
// Revision : 1.0
// ============================================================================
module stack_pop_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter int FLAG_W = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    stack_pop_sequencer_if.master   bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_POP_F = 3'd1;
    localparam logic [2:0] c_POP_L = 3'd2;
    localparam logic [2:0] c_POP_H = 3'd3;
    localparam logic [2:0] c_FIN   = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_nextState;

    logic [ADDR_W-1:0]    r_base;
    logic                 r_mode;
    logic [DATA_W-1:0]    r_pcLow;
    logic [FLAG_W-1:0]    r_flags;

    logic [2*DATA_W-1:0]  r_pcOut;
    logic [FLAG_W-1:0]    r_flagsOut;
    logic [ADDR_W-1:0]    r_spOut;
    logic                 r_done;
    logic                 r_spWe;
    logic                 r_flagsWe;

    logic                 w_memRdEn;
    logic [ADDR_W-1:0]    w_memAddr;
    logic                 w_busy;
    logic [ADDR_W-1:0]    w_modeExt;

    assign w_modeExt = ADDR_W'(r_mode);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; start is only honoured from IDLE, so requests while busy drop.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_nextState = bus.is_rti ? c_POP_F : c_POP_L;
                end
            end
            c_POP_F: w_nextState = c_POP_L;
            c_POP_L: w_nextState = c_POP_H;
            c_POP_H: w_nextState = c_FIN;
            c_FIN:   w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    // Read strobe/address; frame words sit just above the saved stack pointer.
    always_comb begin
        w_memRdEn = 1'b0;
        w_memAddr = '0;
        w_busy    = 1'b0;
        case (r_state)
            c_POP_F: begin
                w_memRdEn = 1'b1;
                w_memAddr = r_base + ADDR_W'(1);
                w_busy    = 1'b1;
            end
            c_POP_L: begin
                w_memRdEn = 1'b1;
                w_memAddr = r_base + ADDR_W'(1) + w_modeExt;
                w_busy    = 1'b1;
            end
            c_POP_H: begin
                w_memRdEn = 1'b1;
                w_memAddr = r_base + ADDR_W'(2) + w_modeExt;
                w_busy    = 1'b1;
            end
            c_FIN: begin
                w_busy    = 1'b1;
            end
            default: begin
                w_memRdEn = 1'b0;
            end
        endcase
    end

    // Datapath: read data lags the strobe by one cycle, so each state captures
    // the word requested by the state before it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_mode     <= 1'b0;
            r_pcLow    <= '0;
            r_flags    <= '0;
            r_pcOut    <= '0;
            r_flagsOut <= '0;
            r_spOut    <= '0;
            r_done     <= 1'b0;
            r_spWe     <= 1'b0;
            r_flagsWe  <= 1'b0;
        end else begin
            r_done    <= (r_state == c_FIN);
            r_spWe    <= (r_state == c_FIN);
            r_flagsWe <= (r_state == c_FIN) && r_mode;

            if (r_state == c_IDLE && bus.start) begin
                r_base <= bus.sp_in;
                r_mode <= bus.is_rti;
            end

            if (r_state == c_POP_L && r_mode) begin
                r_flags <= bus.mem_rd_data[FLAG_W-1:0];
            end

            if (r_state == c_POP_H) begin
                r_pcLow <= bus.mem_rd_data;
            end

            if (r_state == c_FIN) begin
                r_pcOut <= {bus.mem_rd_data, r_pcLow};
                r_spOut <= r_base + ADDR_W'(2) + w_modeExt;
                if (r_mode) begin
                    r_flagsOut <= r_flags;
                end
            end
        end
    end

    assign bus.mem_rd_en = w_memRdEn;
    assign bus.mem_addr  = w_memAddr;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.pc_out    = r_pcOut;
    assign bus.flags_out = r_flagsOut;
    assign bus.flags_we  = r_flagsWe;
    assign bus.sp_out    = r_spOut;
    assign bus.sp_we     = r_spWe;

endmodule
`default_nettype wire

// File: tb/tb_stack_pop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_pop_sequencer
// Purpose  : Directed and random RET/RTI pops checked against a frame model.
// Revision : 1.0
// ============================================================================
module tb_stack_pop_sequencer;

    logic clk;
    logic rst;

    stack_pop_sequencer_if #(.ADDR_W(32), .DATA_W(16), .FLAG_W(4)) bus ();

    stack_pop_sequencer #(.ADDR_W(32), .DATA_W(16), .FLAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] mem [logic [31:0]];
    logic [31:0] modelPc;
    logic [31:0] modelSp;
    logic [3:0]  modelFlags;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= rdMem(bus.mem_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] rdMem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'hDEAD;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pop from the current negedge (cycle 0 of the request). Expected values
    // come from the frame layout: low PC word above the flags, high PC word above that.
    task automatic runPop(input logic [31:0] sp, input logic rti,
                          input int glitchCycle, input bit keepStart);
        int           lat;
        logic [31:0]  expPc;
        logic [31:0]  expSp;
        logic [3:0]   expFlags;
        logic [15:0]  w;
        lat      = rti ? 5 : 4;
        expPc    = {rdMem(sp + 32'd2 + 32'(rti)), rdMem(sp + 32'd1 + 32'(rti))};
        w        = rdMem(sp + 32'd1);
        expFlags = rti ? w[3:0] : modelFlags;
        expSp    = sp + 32'd2 + 32'(rti);
        bus.start  = 1'b1;
        bus.sp_in  = sp;
        bus.is_rti = rti;
        check("idleBusy", {63'd0, bus.busy}, 64'd0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            bus.start = keepStart || (c == glitchCycle);
            if (c == glitchCycle) begin
                bus.sp_in  = ~sp;
                bus.is_rti = ~rti;
            end else begin
                bus.sp_in  = sp;
                bus.is_rti = rti;
            end
            check("rdEn",    {63'd0, bus.mem_rd_en}, {63'd0, (c <= lat - 2)});
            if (c <= lat - 2) check("addr", {32'd0, bus.mem_addr}, {32'd0, sp + 32'(c)});
            check("busy",    {63'd0, bus.busy},     {63'd0, (c <= lat - 1)});
            check("done",    {63'd0, bus.done},     {63'd0, (c == lat)});
            check("spWe",    {63'd0, bus.sp_we},    {63'd0, (c == lat)});
            check("flagsWe", {63'd0, bus.flags_we}, {63'd0, (rti && c == lat)});
        end
        check("pcOut",    {32'd0, bus.pc_out},    {32'd0, expPc});
        check("spOut",    {32'd0, bus.sp_out},    {32'd0, expSp});
        check("flagsOut", {60'd0, bus.flags_out}, {60'd0, expFlags});
        modelPc    = expPc;
        modelSp    = expSp;
        modelFlags = expFlags;
    endtask

    // Cycle after done: single pulse, idle, results held.
    task automatic afterDone();
        @(negedge clk);
        check("donePulse", {63'd0, bus.done},  64'd0);
        check("spWeOff",   {63'd0, bus.sp_we}, 64'd0);
        check("idle",      {63'd0, bus.busy},  64'd0);
        check("pcHold",    {32'd0, bus.pc_out}, {32'd0, modelPc});
        check("spHold",    {32'd0, bus.sp_out}, {32'd0, modelSp});
    endtask

    initial begin
        logic [31:0] sp;
        logic        rti;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.is_rti = 1'b0;
        bus.sp_in  = '0;
        modelPc    = '0;
        modelSp    = '0;
        modelFlags = '0;

        // Reset state
        #1;
        check("rstRdEn",  {63'd0, bus.mem_rd_en}, 64'd0);
        check("rstAddr",  {32'd0, bus.mem_addr},  64'd0);
        check("rstBusy",  {63'd0, bus.busy},      64'd0);
        check("rstDone",  {63'd0, bus.done},      64'd0);
        check("rstPc",    {32'd0, bus.pc_out},    64'd0);
        check("rstFlags", {60'd0, bus.flags_out}, 64'd0);
        check("rstSp",    {32'd0, bus.sp_out},    64'd0);
        check("rstWe",    {62'd0, bus.sp_we, bus.flags_we}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // RET frame
        mem[32'h000FFFFD] = 16'h1234;
        mem[32'h000FFFFE] = 16'h00AB;
        runPop(32'h000FFFFC, 1'b0, 0, 1'b0);
        check("retPc", {32'd0, bus.pc_out}, 64'h00AB1234);
        afterDone();

        // RTI frame
        mem[32'h000FFFF1] = 16'h0005;
        mem[32'h000FFFF2] = 16'hBEEF;
        mem[32'h000FFFF3] = 16'h0000;
        runPop(32'h000FFFF0, 1'b1, 0, 1'b0);
        check("rtiFlags", {60'd0, bus.flags_out}, 64'h5);
        afterDone();

        // Address wrap
        mem[32'h00000000] = 16'h0010;
        mem[32'h00000001] = 16'h0000;
        runPop(32'hFFFFFFFF, 1'b0, 0, 1'b0);
        check("wrapSp", {32'd0, bus.sp_out}, 64'h1);
        afterDone();

        // start re-pulsed during POP_H with a different sp is ignored
        runPop(32'h000FFFFC, 1'b0, 2, 1'b0);
        afterDone();

        // Asynchronous reset during POP_H
        bus.start  = 1'b1;
        bus.sp_in  = 32'h000FFFFC;
        bus.is_rti = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("preRstBusy", {63'd0, bus.busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midRstBusy", {63'd0, bus.busy},      64'd0);
        check("midRstRdEn", {63'd0, bus.mem_rd_en}, 64'd0);
        check("midRstPc",   {32'd0, bus.pc_out},    64'd0);
        @(negedge clk);
        rst = 1'b0;
        modelPc = '0; modelSp = '0; modelFlags = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("noDone", {62'd0, bus.done, bus.sp_we}, 64'd0);
        end
        runPop(32'h000FFFFC, 1'b0, 0, 1'b0);
        afterDone();

        // Back-to-back: start held high through the done cycle
        mem[32'h00001001] = 16'h5678;
        mem[32'h00001002] = 16'h9ABC;
        runPop(32'h000FFFFC, 1'b0, 0, 1'b1);
        runPop(32'h00001000, 1'b0, 0, 1'b0);
        afterDone();

        // Random frames, random RET/RTI mix
        for (int n = 0; n < 24; n++) begin
            sp  = $urandom;
            if (n % 6 == 0) sp = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            rti = 1'($urandom_range(0, 1));
            for (int k = 1; k <= 3; k++) mem[sp + 32'(k)] = 16'($urandom);
            runPop(sp, rti, (n % 5 == 0) ? 2 : 0, 1'b0);
            afterDone();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_pop_sequencer.md
Name: stack_pop_sequencer

Overview:
- Reader side of the processor stack.
- For RET and RTI it pops the return frame that CALL/INT pushed (PC as two 16-bit words, plus flags for RTI) from data memory, one word per cycle.
- Returns the reassembled PC and flags, and the updated stack pointer for the SP register.
- Sits in the memory stage beside the stack-handling logic; holds the pipeline via busy while active.

Parameters:
- ADDR_W, 32, stack pointer / memory address width
- DATA_W, 16, memory word width
- FLAG_W, 4, flags field width (taken from the low FLAG_W bits of the flags word)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  request a pop sequence; sampled only in IDLE
- is_rti  input  1  1 = RTI frame (flags + PC), 0 = RET frame (PC only); sampled with start
- sp_in  input  ADDR_W  current stack pointer; sampled with start
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_W  memory read address
- mem_rd_data  input  DATA_W  read data, valid the cycle after mem_rd_en (synchronous memory)
- busy  output  1  sequence in progress; pipeline stall request
- done  output  1  one-cycle pulse: pc_out, flags_out, sp_out and sp_we are valid
- pc_out  output  2*DATA_W  popped PC
- flags_out  output  FLAG_W  popped flags (RTI only)
- flags_we  output  1  pulses with done for RTI only
- sp_out  output  ADDR_W  new stack pointer
- sp_we  output  1  pulses with done; SP register load enable

Behaviour:
- Frame layout (stack grows down; push writes at SP then decrements):
  - CALL pushed PC[31:16] at S, then PC[15:0] at S-1.
  - INT additionally pushed flags at S-2.
  - A pop pre-increments the address.
- Reset values (asynchronous, immediate): state=IDLE, and all outputs 0 (mem_rd_en, mem_addr, busy, done, pc_out, flags_out, flags_we, sp_out, sp_we). Internal latches are also 0.
- States: IDLE, POP_F, POP_L, POP_H, FIN.
- IDLE:
  - mem_rd_en=0, mem_addr=0.
  - On start=1, latch sp_in into base and is_rti into mode, then go to POP_F if is_rti, else POP_L.
- POP_F: mem_rd_en=1, mem_addr=base+1; next state POP_L.
- POP_L:
  - mem_rd_en=1, mem_addr=base+1+mode.
  - If mode=1, capture mem_rd_data[FLAG_W-1:0] into the flags register at the end of this cycle.
  - Next state POP_H.
- POP_H:
  - mem_rd_en=1, mem_addr=base+2+mode.
  - Capture mem_rd_data into pc[15:0] at the end of this cycle.
  - Next state FIN.
- FIN:
  - mem_rd_en=0.
  - Capture mem_rd_data into pc[31:16].
  - Register sp_out=base+2+mode, pc_out, flags_out.
  - Next state IDLE.
  - In the following cycle, done=1, sp_we=1, and flags_we=mode.
- busy=1 in POP_F, POP_L, POP_H and FIN; 0 in IDLE, including the done cycle.
- Latency (start sampled at edge 0): RET has done high in cycle 4, RTI in cycle 5. Every mem_rd_en cycle is consecutive, with no gaps.
- pc_out, flags_out and sp_out hold their last values until the next sequence completes. flags_out is unchanged by RET.
- Arithmetic: all address and SP additions are modulo 2^ADDR_W; wrap-around is silent.
- start while busy: ignored; no queuing.
- start in the done cycle: accepted (state is IDLE). The new sequence proceeds normally; the previous done pulse is unaffected.
- sp_in and is_rti changing after start: no effect on the current sequence.
- rst mid-sequence: immediate return to IDLE with all outputs 0. No done, sp_we or flags_we is emitted; the partial frame is discarded.

Test Plan:
- RET, sp_in=0x000FFFFC, mem[0xFFFFD]=0x1234, mem[0xFFFFE]=0x00AB:
  - Reads at 0xFFFFD then 0xFFFFE.
  - Done in cycle 4 with pc_out=0x00AB1234, sp_out=0x000FFFFE, sp_we=1, flags_we=0.
- RTI, sp_in=0x000FFFF0, mem[0xFFFF1]=0x0005, [0xFFFF2]=0xBEEF, [0xFFFF3]=0x0000:
  - Done in cycle 5 with flags_out=4'h5, flags_we=1, pc_out=0x0000BEEF, sp_out=0x000FFFF3.
- Wrap, RET, sp_in=0xFFFFFFFF, mem[0]=0x0010, mem[1]=0x0000:
  - mem_addr is 0x00000000 then 0x00000001.
  - pc_out=0x00000010, sp_out=0x00000001.
- start pulsed again during POP_H with a different sp_in: ignored; results match the first request, and exactly one done pulse occurs.
- rst asserted asynchronously during POP_H: busy and mem_rd_en fall immediately; no done or sp_we follows. A subsequent RET completes correctly.
- Back-to-back: start held high through a RET done cycle: second RET begins on the done cycle's edge and its done arrives 4 cycles later.
